bnn_core_sequencer: RTL and testbench
=====================================

Name: bnn_core_sequencer

Overview:
Layer-level controller that drives the 20-bit instruction bus of the BNN core (16 BPUGs, bias/accumulator bank, optional 2x2 OR-pooling, 8x8-bit result bin register).
Per layer it runs five phases: load BPUG enable/height config, load 8 bias bytes, accumulate partial sums over the selected BPUGs, binarize (with or without pooling), and store result bins in 32-bit halves.
It sits between the layer host/DMA, which supplies data_in words and start/config, and the core instance.

Parameters:
CW, 8, width of group counter (cfg_ngroups)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  begin layer; sampled only in IDLE
cfg_nbpug  input  4  BPUGs to accumulate per window, minus 1 (0..15 -> 1..16)
cfg_ngroups  input  CW  8-bin output groups per layer, minus 1
cfg_pool  input  1  1 = 2x2 pooling (4 windows per bin)
cfg_wgt  input  3  weight select driven on instruction[19:17] for whole layer
data_valid  input  1  upstream data_in word valid this cycle
data_req  output  1  sequencer consumes data_in this cycle if data_valid
out_ready  input  1  consumer accepts result half this cycle
out_valid  output  1  result_bins on core is valid (store asserted)
instruction  output  20  core instruction word
busy  output  1  layer in progress
done  output  1  one-cycle pulse at layer end

Behaviour:
- Reset: state IDLE; instruction=0, data_req=0, out_valid=0, busy=0, done=0; all counters 0. Reset mid-layer aborts immediately, no done pulse.
- Config (cfg_*) latched on the accepted start; later changes are ignored until the next start. start outside IDLE is ignored.
- Counters: k (bpug 0..nbpug), p (pool window 0..3), b (bin 0..7), g (group 0..ngroups).
- instruction[19:17]=cfg_wgt in every non-IDLE/non-DONE state. All other bits are 0 unless listed below.
- IDLE: on start go to CFG.
- CFG: bits 15 and 8 set (enable/height load). data_req=1. Advance to BIAS0 only when data_valid=1. While data_valid=0, instruction=0 (stall bubble, bit 17-19 kept).
- BIAS0, BIAS1: bit 11 set, data_req=1, same stall rule. BIAS1 goes to CLR.
- CLR: bit 0 set (accumulators <= bias), 1 cycle, k=0, then go to ACC.
- ACC: bit 9 set, bits[4:1]=k, data_req=1. On data_valid: if k==nbpug go to BIN, else k++. Stalls emit the bubble.
- BIN: bit 10 set.
  - cfg_pool=1: bit 12 set, bit13=p[1], bit6=p[0]. If p<3: p++ and return to CLR. If p==3: p=0 and the bin is complete.
  - cfg_pool=0: the bin is complete every BIN.
  - Bin complete: if b<7, b++ and return to CLR; else b=0 and go to ST0.
- ST0: bit 14 set, bit 6=0, out_valid=1. Hold until out_ready, then ST1.
- ST1: bit 14 set, bit 6=1, out_valid=1. Hold until out_ready. Then if g<ngroups, g++ and go to CLR; else go to DONE.
- DONE: done=1 for 1 cycle, instruction=0, then IDLE.
- busy=1 in every state except IDLE and DONE.
- Exactly one instruction per cycle; no combinational path from data_valid/out_ready to instruction other than the stall bubble select.
- Counters wrap only through the explicit transitions above; b and p never exceed 7 and 3.

Test Plan:
- Reset mid-ACC (k=5) -> next cycle IDLE, instruction=0, busy=0, no done.
- cfg_pool=0, cfg_nbpug=0, cfg_ngroups=0, data_valid=out_ready=1, start -> busy high exactly 29 cycles (1+2+8x3+2); done pulses on cycle 30; ACC words all have bits[4:1]=0 and bit 9=1.
- cfg_pool=1, same otherwise -> busy 101 cycles (3+8x12+2); BIN words cycle pooling_cnt {bit13,bit6} through 0,1,2,3; bit 12 set on every BIN.
- cfg_nbpug=15, cfg_wgt=5 -> each window shows 16 ACC words with bits[4:1]=0..15 in order; bits[19:17]=5 throughout.
- data_valid toggled 1,0,1,0 during CFG/BIAS/ACC -> each 0 cycle gives a bubble (bits[16:0]=0) and no counter advance; result sequence identical to the no-stall run.
- out_ready low 3 cycles in ST0, cfg_ngroups=1 -> ST0 held 4 cycles with out_valid=1, then ST1, then CLR of group 1; done only after the second ST1.

Source files
------------

// File: rtl/bnn_core_sequencer.sv
// Layer-level sequencer for the BNN core. It walks the config, bias, clear,
// accumulate, binarize and store phases, and emits one 20-bit core
// instruction per cycle. While an upstream data word is awaited, the
// instruction collapses to a bubble that keeps only the weight-select field.
module bnn_core_sequencer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    cfg_nbpug,
    input  logic [CW-1:0] cfg_ngroups,
    input  logic          cfg_pool,
    input  logic [2:0]    cfg_wgt,
    input  logic          data_valid,
    output logic          data_req,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [19:0]   instruction,
    output logic          busy,
    output logic          done
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CFG   = 4'd1;
    localparam logic [3:0] S_BIAS0 = 4'd2;
    localparam logic [3:0] S_BIAS1 = 4'd3;
    localparam logic [3:0] S_CLR   = 4'd4;
    localparam logic [3:0] S_ACC   = 4'd5;
    localparam logic [3:0] S_BIN   = 4'd6;
    localparam logic [3:0] S_ST0   = 4'd7;
    localparam logic [3:0] S_ST1   = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    logic [3:0]    state_reg;
    logic [3:0]    nbpug_reg;
    logic [CW-1:0] ngroups_reg;
    logic          pool_reg;
    logic [2:0]    wgt_reg;
    logic [3:0]    k_reg;
    logic [1:0]    p_reg;
    logic [2:0]    b_reg;
    logic [CW-1:0] g_reg;
    logic [16:0]   field_word;
    logic          active;

    // State machine, layer config latch and the bpug/window/bin/group counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            nbpug_reg   <= '0;
            ngroups_reg <= '0;
            pool_reg    <= 1'b0;
            wgt_reg     <= '0;
            k_reg       <= '0;
            p_reg       <= '0;
            b_reg       <= '0;
            g_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        nbpug_reg   <= cfg_nbpug;
                        ngroups_reg <= cfg_ngroups;
                        pool_reg    <= cfg_pool;
                        wgt_reg     <= cfg_wgt;
                        k_reg       <= '0;
                        p_reg       <= '0;
                        b_reg       <= '0;
                        g_reg       <= '0;
                        state_reg   <= S_CFG;
                    end
                end
                S_CFG:   if (data_valid) state_reg <= S_BIAS0;
                S_BIAS0: if (data_valid) state_reg <= S_BIAS1;
                S_BIAS1: if (data_valid) state_reg <= S_CLR;
                S_CLR: begin
                    k_reg     <= '0;
                    state_reg <= S_ACC;
                end
                S_ACC: begin
                    if (data_valid) begin
                        if (k_reg == nbpug_reg) state_reg <= S_BIN;
                        else                    k_reg     <= k_reg + 4'd1;
                    end
                end
                S_BIN: begin
                    if (pool_reg && (p_reg != 2'd3)) begin
                        p_reg     <= p_reg + 2'd1;
                        state_reg <= S_CLR;
                    end else begin
                        // Bin finished: either move to the next bin or store the group
                        p_reg <= '0;
                        if (b_reg != 3'd7) begin
                            b_reg     <= b_reg + 3'd1;
                            state_reg <= S_CLR;
                        end else begin
                            b_reg     <= '0;
                            state_reg <= S_ST0;
                        end
                    end
                end
                S_ST0: if (out_ready) state_reg <= S_ST1;
                S_ST1: begin
                    if (out_ready) begin
                        if (g_reg < ngroups_reg) begin
                            g_reg     <= g_reg + CW'(1);
                            state_reg <= S_CLR;
                        end else begin
                            g_reg     <= '0;
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Instruction decode from the current state; data stalls zero the low 17 bits
    always_comb begin
        field_word = '0;
        case (state_reg)
            S_CFG: begin
                field_word[15] = 1'b1;
                field_word[8]  = 1'b1;
            end
            S_BIAS0, S_BIAS1: field_word[11] = 1'b1;
            S_CLR:            field_word[0]  = 1'b1;
            S_ACC: begin
                field_word[9]   = 1'b1;
                field_word[4:1] = k_reg;
            end
            S_BIN: begin
                field_word[10] = 1'b1;
                if (pool_reg) begin
                    field_word[12] = 1'b1;
                    field_word[13] = p_reg[1];
                    field_word[6]  = p_reg[0];
                end
            end
            S_ST0: field_word[14] = 1'b1;
            S_ST1: begin
                field_word[14] = 1'b1;
                field_word[6]  = 1'b1;
            end
            default: field_word = '0;
        endcase
        if (data_req && !data_valid) field_word = '0;
    end

    assign active      = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign busy        = active;
    assign done        = (state_reg == S_DONE);
    assign data_req    = (state_reg == S_CFG) || (state_reg == S_BIAS0) ||
                         (state_reg == S_BIAS1) || (state_reg == S_ACC);
    assign out_valid   = (state_reg == S_ST0) || (state_reg == S_ST1);
    assign instruction = active ? {wgt_reg, field_word} : 20'd0;

endmodule

// File: tb/tb_bnn_core_sequencer.sv
// Testbench for bnn_core_sequencer. A reference model expands each layer
// config into its expected instruction list. Every cycle, the bench compares
// the DUT against that list and applies the stall and hold rules for the
// data and store handshakes.
module tb_bnn_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_nbpug;
    logic [7:0]  cfg_ngroups;
    logic        cfg_pool;
    logic [2:0]  cfg_wgt;
    logic        data_valid;
    logic        data_req;
    logic        out_ready;
    logic        out_valid;
    logic [19:0] instruction;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] nbpug;
        logic [7:0] ngroups;
        logic       pool;
        logic [2:0] wgt;
        int         mode;      // 0 free-flow, 1 data toggle, 2 random, 3 store hold
        int         exp_busy;  // busy cycles without stalls, -1 = take from model
    } vec_t;

    typedef struct {
        logic [19:0] instr;
        bit          need_data;
        bit          need_ready;
    } step_t;

    step_t steps[$];
    vec_t  vecs[6];

    bnn_core_sequencer #(.CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_nbpug  (cfg_nbpug),
        .cfg_ngroups(cfg_ngroups),
        .cfg_pool   (cfg_pool),
        .cfg_wgt    (cfg_wgt),
        .data_valid (data_valid),
        .data_req   (data_req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .instruction(instruction),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expand a layer into the ordered list of instructions it must produce
    task automatic build_steps(input vec_t v);
        logic [19:0] w;
        int np;
        w  = {v.wgt, 17'd0};
        np = v.pool ? 4 : 1;
        steps.delete();
        steps.push_back('{w | 20'h08100, 1'b1, 1'b0});
        steps.push_back('{w | 20'h00800, 1'b1, 1'b0});
        steps.push_back('{w | 20'h00800, 1'b1, 1'b0});
        for (int g = 0; g <= int'(v.ngroups); g++) begin
            for (int b = 0; b < 8; b++) begin
                for (int p = 0; p < np; p++) begin
                    logic [19:0] bw;
                    steps.push_back('{w | 20'h00001, 1'b0, 1'b0});
                    for (int k = 0; k <= int'(v.nbpug); k++)
                        steps.push_back('{w | 20'h00200 | 20'(k * 2), 1'b1, 1'b0});
                    bw = w | 20'h00400;
                    if (v.pool) bw = bw | 20'h01000 | ((p / 2 == 1) ? 20'h02000 : 20'h0)
                                        | ((p % 2 == 1) ? 20'h00040 : 20'h0);
                    steps.push_back('{bw, 1'b0, 1'b0});
                end
            end
            steps.push_back('{w | 20'h04000, 1'b0, 1'b1});
            steps.push_back('{w | 20'h04040, 1'b0, 1'b1});
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " instruction"}, 32'(instruction), 32'd0);
        check({tag, " busy"},        32'(busy),        32'd0);
        check({tag, " done"},        32'(done),        32'd0);
        check({tag, " data_req"},    32'(data_req),    32'd0);
        check({tag, " out_valid"},   32'(out_valid),   32'd0);
    endtask

    // Run one layer, comparing every cycle against the expanded step list
    task automatic run_layer(input vec_t v, input int id);
        int idx, cycles, stalls, busy_seen, hold_cnt, bound, exp_busy;
        bit dv, rd, adv, tog;
        step_t s;
        logic [19:0] exp_instr;
        string tag;
        tag = $sformatf("layer%0d", id);
        build_steps(v);
        exp_busy = (v.exp_busy >= 0) ? v.exp_busy : steps.size();
        @(negedge clk);
        cfg_nbpug = v.nbpug; cfg_ngroups = v.ngroups; cfg_pool = v.pool; cfg_wgt = v.wgt;
        start = 1'b1; data_valid = 1'b0; out_ready = 1'b0;
        #1 check_idle({tag, " idle"});
        @(posedge clk);
        idx = 0; cycles = 0; stalls = 0; busy_seen = 0; hold_cnt = 0; tog = 1'b1;
        bound = steps.size() * 8 + 100;
        while (idx < steps.size() && cycles < bound) begin
            @(negedge clk);
            s = steps[idx];
            case (v.mode)
                1:       begin dv = tog; rd = 1'b1; tog = ~tog; end
                2:       begin dv = ($urandom_range(0, 3) != 0); rd = ($urandom_range(0, 2) != 0); end
                3:       begin dv = 1'b1; rd = (hold_cnt >= 3); end
                default: begin dv = 1'b1; rd = 1'b1; end
            endcase
            data_valid = dv; out_ready = rd;
            // config and start changes mid-layer must have no effect
            start = 1'($urandom_range(0, 1));
            cfg_nbpug = 4'($urandom); cfg_ngroups = 8'($urandom);
            cfg_pool = 1'($urandom); cfg_wgt = 3'($urandom);
            #1;
            exp_instr = (s.need_data && !dv) ? {v.wgt, 17'd0} : s.instr;
            adv = s.need_data ? dv : (s.need_ready ? rd : 1'b1);
            check($sformatf("%s step%0d instruction", tag, idx), 32'(instruction), 32'(exp_instr));
            check($sformatf("%s step%0d data_req", tag, idx),    32'(data_req),    32'(s.need_data));
            check($sformatf("%s step%0d out_valid", tag, idx),   32'(out_valid),   32'(s.need_ready));
            check($sformatf("%s step%0d done", tag, idx),        32'(done),        32'd0);
            if (busy) busy_seen++;
            if (adv) begin idx++; hold_cnt = 0; end
            else begin stalls++; hold_cnt++; end
            cycles++;
        end
        if (idx < steps.size()) begin
            check({tag, " timeout step"}, 32'(idx), 32'(steps.size()));
        end
        @(negedge clk);
        start = 1'b0; data_valid = 1'b0; out_ready = 1'b0;
        #1;
        check({tag, " end done"},        32'(done),        32'd1);
        check({tag, " end busy"},        32'(busy),        32'd0);
        check({tag, " end instruction"}, 32'(instruction), 32'd0);
        check({tag, " busy cycles"},     32'(busy_seen),   32'(exp_busy + stalls));
        @(negedge clk);
        #1 check_idle({tag, " after"});
        $display("layer %0d nbpug=%0d ngroups=%0d pool=%0d wgt=%0d mode=%0d steps=%0d stalls=%0d",
                 id, v.nbpug, v.ngroups, v.pool, v.wgt, v.mode, steps.size(), stalls);
    endtask

    initial begin
        bit found;
        vec_t rv;
        rst = 1'b1; start = 1'b0; cfg_nbpug = '0; cfg_ngroups = '0; cfg_pool = 1'b0;
        cfg_wgt = '0; data_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        vecs[0] = '{4'd0,  8'd0, 1'b0, 3'd3, 0, 29};
        vecs[1] = '{4'd0,  8'd0, 1'b1, 3'd2, 0, 101};
        vecs[2] = '{4'd15, 8'd0, 1'b0, 3'd5, 0, 149};
        vecs[3] = '{4'd0,  8'd0, 1'b0, 3'd1, 1, 29};
        vecs[4] = '{4'd0,  8'd1, 1'b0, 3'd6, 3, 55};
        vecs[5] = '{4'd1,  8'd0, 1'b1, 3'd7, 2, 133};
        for (int i = 0; i < 6; i++) run_layer(vecs[i], i);

        for (int i = 0; i < 6; i++) begin
            rv.nbpug   = 4'($urandom_range(0, 3));
            rv.ngroups = 8'($urandom_range(0, 2));
            rv.pool    = 1'($urandom_range(0, 1));
            rv.wgt     = 3'($urandom);
            rv.mode    = 2;
            rv.exp_busy = -1;
            run_layer(rv, 10 + i);
        end

        // Reset in the middle of ACC with k=5 aborts without a done pulse
        @(negedge clk);
        cfg_nbpug = 4'd7; cfg_ngroups = 8'd0; cfg_pool = 1'b0; cfg_wgt = 3'd4;
        start = 1'b1; data_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (instruction[9] && instruction[4:1] == 4'd5) found = 1'b1;
        end
        check("midacc k5 reached", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 check_idle("midacc reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check_idle("midacc idle1");
        @(negedge clk);
        #1 check_idle("midacc idle2");
        $display("reset mid-ACC sequence complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
